rv32_imem_responder: RTL and testbench

//  Responder end of the instruction bus driven by the fetch stage.
//  - Accepts memory_request_t and answers with memory_response_t from a word-addressed synchronous instruction RAM.
//  - Supports a configurable number of wait states.
//  - Aborts a read when the requested address changes (pc redirect).
//  - Provides a host program-load write port.
//  - Sits between the core fetch port and instruction memory in the SoC.

---
 rtl/rv32_imem_responder.sv | 155 +++++++++++++++
 tb/tb_rv32_imem_responder.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_imem_responder.sv
// Instruction-bus responder: answers fetch requests from a word-addressed synchronous RAM
// after a fixed number of wait states, with a host program-load port and a sticky fault flag.

package rv32_imem_pkg;

    typedef logic [31:0] rv32_word;

    typedef enum logic [1:0] {
        MEM_NOP = 2'd0,
        MEM_LW  = 2'd1,
        MEM_SW  = 2'd2
    } mem_op_t;

    typedef struct packed {
        rv32_word addr;
        mem_op_t  op;
    } memory_request_t;

    typedef struct packed {
        logic     ready;
        rv32_word data;
    } memory_response_t;

    localparam rv32_word RV_NOP = 32'h0000_0013;

endpackage

module rv32_imem_responder
    import rv32_imem_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 4096,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    input  memory_request_t  instr_request,
    output memory_response_t instr_response,
    input  logic             prog_we,
    input  logic [31:0]      prog_addr,
    input  logic [31:0]      prog_data,
    output logic             fault,
    output logic [31:0]      fault_addr,
    output logic [1:0]       dbg_state
);

    localparam int unsigned IDX_W = $clog2(MEM_WORDS);
    localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    rv32_word   lat_addr;
    logic       lat_illegal;
    rv32_word   ram_q;
    rv32_word   mem [MEM_WORDS];

    logic [31:0]      req_off;
    logic [31:0]      prog_off;
    logic             req_in_range;
    logic             prog_in_range;
    logic             req_valid;
    logic             req_legal;
    logic             addr_changed;
    logic             resp_ready;
    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] prog_idx;

    // Range checks use 33-bit compares so the top of memory cannot wrap onto word 0.
    assign req_off       = instr_request.addr - BASE_ADDR;
    assign prog_off      = prog_addr - BASE_ADDR;
    assign req_in_range  = (instr_request.addr >= BASE_ADDR) && ({1'b0, req_off} < SPAN);
    assign prog_in_range = (prog_addr >= BASE_ADDR) && ({1'b0, prog_off} < SPAN)
                           && (prog_off[1:0] == 2'b00);
    assign req_idx       = req_off[IDX_W+1:2];
    assign prog_idx      = prog_off[IDX_W+1:2];

    // Handshake: a request is valid while op != MEM_NOP and the requester holds addr
    // until it sees ready; ready is a one-cycle pulse, and any addr change before then
    // abandons the outstanding read without a response.
    assign req_valid    = (instr_request.op != MEM_NOP);
    assign req_legal    = (instr_request.op == MEM_LW) && (instr_request.addr[1:0] == 2'b00)
                          && req_in_range;
    assign addr_changed = (instr_request.addr != lat_addr);

    // Read-first RAM: a same-edge program write does not affect the word being read.
    always_ff @(posedge clk) begin
        if (prog_we && prog_in_range) begin
            mem[prog_idx] <= prog_data;
        end
        if ((state == IDLE) && req_valid && req_legal) begin
            ram_q <= mem[req_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            lat_addr    <= '0;
            lat_illegal <= 1'b0;
            fault       <= 1'b0;
            fault_addr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr    <= instr_request.addr;
                        lat_illegal <= !req_legal;
                        cnt         <= 4'(WAIT_STATES);
                        state       <= (WAIT_STATES > 0) ? WAIT : RESP;
                        if (!req_legal && !fault) begin
                            fault      <= 1'b1;
                            fault_addr <= instr_request.addr;
                        end
                    end
                end
                WAIT: begin
                    if (addr_changed) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                        if (cnt == 4'd1) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign resp_ready = (state == RESP) && !addr_changed;

    always_comb begin
        instr_response.ready = resp_ready;
        instr_response.data  = '0;
        if (resp_ready) begin
            instr_response.data = lat_illegal ? RV_NOP : ram_q;
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_rv32_imem_responder.sv
// Bench for rv32_imem_responder: two instances (one wait state at base 0, zero wait states
// at a non-zero base) checked against a word-array reference model.

module tb_rv32_imem_responder;
    import rv32_imem_pkg::*;

    localparam int unsigned WS_A    = 1;
    localparam int unsigned WORDS_A = 4096;
    localparam logic [31:0] BASE_A  = 32'h0;
    localparam int unsigned WS_B    = 0;
    localparam int unsigned WORDS_B = 64;
    localparam logic [31:0] BASE_B  = 32'h100;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             reset_a, reset_b;
    memory_request_t  req_a, req_b;
    memory_response_t rsp_a, rsp_b;
    logic             prog_we_a, prog_we_b;
    logic [31:0]      prog_addr_a, prog_addr_b, prog_data_a, prog_data_b;
    logic             fault_a, fault_b;
    logic [31:0]      fault_addr_a, fault_addr_b;
    logic [1:0]       dbg_a, dbg_b;

    rv32_imem_responder #(.MEM_WORDS(WORDS_A), .WAIT_STATES(WS_A), .BASE_ADDR(BASE_A)) dut_a (
        .clk(clk), .reset(reset_a), .instr_request(req_a), .instr_response(rsp_a),
        .prog_we(prog_we_a), .prog_addr(prog_addr_a), .prog_data(prog_data_a),
        .fault(fault_a), .fault_addr(fault_addr_a), .dbg_state(dbg_a)
    );

    rv32_imem_responder #(.MEM_WORDS(WORDS_B), .WAIT_STATES(WS_B), .BASE_ADDR(BASE_B)) dut_b (
        .clk(clk), .reset(reset_b), .instr_request(req_b), .instr_response(rsp_b),
        .prog_we(prog_we_b), .prog_addr(prog_addr_b), .prog_data(prog_data_b),
        .fault(fault_b), .fault_addr(fault_addr_b), .dbg_state(dbg_b)
    );

    // ---------------- reference model ----------------
    logic [31:0] ref_a [WORDS_A];
    logic [31:0] ref_b [WORDS_B];
    logic        exp_fault [2];
    logic [31:0] exp_fault_addr [2];
    int pass_cnt = 0;
    int total_cnt = 0;

    function automatic logic [31:0] base_of(input bit sel);
        return sel ? BASE_B : BASE_A;
    endfunction

    function automatic longint words_of(input bit sel);
        return sel ? longint'(WORDS_B) : longint'(WORDS_A);
    endfunction

    function automatic int ws_of(input bit sel);
        return sel ? int'(WS_B) : int'(WS_A);
    endfunction

    function automatic bit ref_legal(input bit sel, input logic [31:0] addr, input mem_op_t op);
        longint a, lo, hi;
        a  = longint'(addr);
        lo = longint'(base_of(sel));
        hi = lo + 4 * words_of(sel);
        return (op == MEM_LW) && (a % 4 == 0) && (a >= lo) && (a < hi);
    endfunction

    task automatic ref_fetch(input bit sel, input logic [31:0] addr, input mem_op_t op,
                             output logic [31:0] exp_word);
        int idx;
        if (ref_legal(sel, addr, op)) begin
            idx = int'((longint'(addr) - longint'(base_of(sel))) / 4);
            exp_word = sel ? ref_b[idx] : ref_a[idx];
        end else begin
            exp_word = 32'h0000_0013;
            if (!exp_fault[sel]) begin
                exp_fault[sel]      = 1'b1;
                exp_fault_addr[sel] = addr;
            end
        end
    endtask

    task automatic ref_prog(input bit sel, input logic [31:0] addr, input logic [31:0] data);
        int idx;
        if (ref_legal(sel, addr, MEM_LW)) begin
            idx = int'((longint'(addr) - longint'(base_of(sel))) / 4);
            if (sel) ref_b[idx] = data;
            else     ref_a[idx] = data;
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic cur_ready(input bit sel);
        return sel ? rsp_b.ready : rsp_a.ready;
    endfunction

    function automatic logic [31:0] cur_data(input bit sel);
        return sel ? rsp_b.data : rsp_a.data;
    endfunction

    function automatic logic cur_fault(input bit sel);
        return sel ? fault_b : fault_a;
    endfunction

    function automatic logic [31:0] cur_fault_addr(input bit sel);
        return sel ? fault_addr_b : fault_addr_a;
    endfunction

    task automatic drive_req(input bit sel, input logic [31:0] addr, input mem_op_t op);
        if (sel) begin req_b.addr = addr; req_b.op = op; end
        else     begin req_a.addr = addr; req_a.op = op; end
    endtask

    task automatic set_prog(input bit sel, input logic we, input logic [31:0] addr,
                            input logic [31:0] data);
        if (sel) begin prog_we_b = we; prog_addr_b = addr; prog_data_b = data; end
        else     begin prog_we_a = we; prog_addr_a = addr; prog_data_a = data; end
    endtask

    task automatic prog_word(input bit sel, input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        set_prog(sel, 1'b1, addr, data);
        ref_prog(sel, addr, data);
        @(negedge clk);
        set_prog(sel, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic idle(input bit sel, input int n);
        repeat (n) begin
            @(negedge clk);
            drive_req(sel, 32'hFFFF_FFF0, MEM_NOP);
        end
    endtask

    // Counts cycles from the current one until ready; -1 when the budget expires.
    task automatic wait_ready(input bit sel, output int lat, output logic [31:0] data);
        lat  = -1;
        data = '0;
        for (int k = 0; k < 24; k++) begin
            #1;
            if (cur_ready(sel)) begin
                lat  = k;
                data = cur_data(sel);
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic fetch(input bit sel, input logic [31:0] addr, input mem_op_t op,
                         output int lat, output logic [31:0] data);
        @(negedge clk);
        drive_req(sel, addr, op);
        wait_ready(sel, lat, data);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_a = 1'b1; reset_b = 1'b1;
        drive_req(0, 32'h0, MEM_NOP); drive_req(1, 32'h0, MEM_NOP);
        set_prog(0, 1'b0, 32'h0, 32'h0); set_prog(1, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            total_cnt++;
            if (cur_ready(s[0]) !== 1'b0) $display("FAIL reset_ready[%0d]: got %b expected 0", s, cur_ready(s[0]));
            else pass_cnt++;
            total_cnt++;
            if (cur_data(s[0]) !== 32'h0) $display("FAIL reset_data[%0d]: got %h expected 0", s, cur_data(s[0]));
            else pass_cnt++;
            total_cnt++;
            if (cur_fault(s[0]) !== 1'b0) $display("FAIL reset_fault[%0d]: got %b expected 0", s, cur_fault(s[0]));
            else pass_cnt++;
            total_cnt++;
            if (cur_fault_addr(s[0]) !== 32'h0) $display("FAIL reset_fault_addr[%0d]: got %h expected 0", s, cur_fault_addr(s[0]));
            else pass_cnt++;
            exp_fault[s] = 1'b0;
            exp_fault_addr[s] = 32'h0;
        end
        reset_a = 1'b0; reset_b = 1'b0;
    endtask

    task automatic test_single_fetch();
        int lat;
        logic [31:0] data, exp;
        prog_word(0, 32'h0, 32'h0050_0093);
        idle(0, 1);
        ref_fetch(0, 32'h0, MEM_LW, exp);
        fetch(0, 32'h0, MEM_LW, lat, data);
        total_cnt++;
        if (lat != WS_A + 1) $display("FAIL single_latency: got %0d expected %0d", lat, WS_A + 1);
        else pass_cnt++;
        total_cnt++;
        if (data !== 32'h0050_0093) $display("FAIL single_data: got %h expected %h", data, 32'h0050_0093);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (rsp_a.ready !== 1'b0) $display("FAIL single_pulse: got ready %b expected 0", rsp_a.ready);
        else pass_cnt++;
        total_cnt++;
        if (rsp_a.data !== 32'h0) $display("FAIL single_data_idle: got %h expected 0", rsp_a.data);
        else pass_cnt++;
        idle(0, 2);
    endtask

    task automatic preload();
        for (int i = 1; i < 64; i++) prog_word(0, BASE_A + 32'(4 * i), $urandom);
        for (int i = 0; i < 64; i++) prog_word(1, BASE_B + 32'(4 * i), $urandom);
        idle(0, 1); idle(1, 1);
    endtask

    task automatic test_back_to_back(input bit sel);
        int lat;
        int unsigned rdy_cyc [3];
        logic [31:0] data, exp, addr;
        for (int i = 0; i < 3; i++) begin
            addr = base_of(sel) + 32'(4 * i);
            ref_fetch(sel, addr, MEM_LW, exp);
            fetch(sel, addr, MEM_LW, lat, data);
            rdy_cyc[i] = cyc;
            total_cnt++;
            if (data !== exp) $display("FAIL b2b_data[%0d,%0d]: got %h expected %h", sel, i, data, exp);
            else pass_cnt++;
            total_cnt++;
            if (lat != ws_of(sel) + 1) $display("FAIL b2b_latency[%0d,%0d]: got %0d expected %0d", sel, i, lat, ws_of(sel) + 1);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (rdy_cyc[i] - rdy_cyc[i-1] != ws_of(sel) + 2)
                    $display("FAIL b2b_spacing[%0d,%0d]: got %0d expected %0d", sel, i, rdy_cyc[i] - rdy_cyc[i-1], ws_of(sel) + 2);
                else pass_cnt++;
            end
        end
        idle(sel, 1);
    endtask

    task automatic test_abort(input bit sel, input logic [31:0] a, input logic [31:0] b, input int c);
        int lat;
        logic seen;
        logic [31:0] data, exp;
        seen = 1'b0;
        @(negedge clk);
        drive_req(sel, a, MEM_LW);
        #1;
        if (cur_ready(sel)) seen = 1'b1;
        for (int j = 1; j < c; j++) begin
            @(negedge clk);
            #1;
            if (cur_ready(sel)) seen = 1'b1;
        end
        @(negedge clk);
        drive_req(sel, b, MEM_LW);
        ref_fetch(sel, b, MEM_LW, exp);
        wait_ready(sel, lat, data);
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL abort_no_ready[%h]: got ready before change, expected none", a);
        else pass_cnt++;
        total_cnt++;
        if (lat != ws_of(sel) + 2) $display("FAIL abort_latency[%h->%h]: got %0d expected %0d", a, b, lat, ws_of(sel) + 2);
        else pass_cnt++;
        total_cnt++;
        if (data !== exp) $display("FAIL abort_data[%h]: got %h expected %h", b, data, exp);
        else pass_cnt++;
        idle(sel, 1);
    endtask

    task automatic checked_fetch(input bit sel, input logic [31:0] addr, input mem_op_t op);
        int lat;
        logic [31:0] data, exp;
        ref_fetch(sel, addr, op, exp);
        fetch(sel, addr, op, lat, data);
        total_cnt++;
        if (lat != ws_of(sel) + 1) $display("FAIL fetch_latency[%0d,%h]: got %0d expected %0d", sel, addr, lat, ws_of(sel) + 1);
        else pass_cnt++;
        total_cnt++;
        if (data !== exp) $display("FAIL fetch_data[%0d,%h]: got %h expected %h", sel, addr, data, exp);
        else pass_cnt++;
        total_cnt++;
        if (cur_fault(sel) !== exp_fault[sel]) $display("FAIL fetch_fault[%0d,%h]: got %b expected %b", sel, addr, cur_fault(sel), exp_fault[sel]);
        else pass_cnt++;
        total_cnt++;
        if (cur_fault_addr(sel) !== exp_fault_addr[sel]) $display("FAIL fetch_fault_addr[%0d,%h]: got %h expected %h", sel, addr, cur_fault_addr(sel), exp_fault_addr[sel]);
        else pass_cnt++;
        idle(sel, 1);
    endtask

    task automatic test_illegal();
        checked_fetch(0, 32'h2, MEM_LW);
        checked_fetch(0, 32'h4000, MEM_LW);
        checked_fetch(0, 32'h0, MEM_SW);
        checked_fetch(0, 32'h0, MEM_LW);
        checked_fetch(1, BASE_B - 32'h4, MEM_LW);
        checked_fetch(1, BASE_B + 32'(4 * WORDS_B), MEM_LW);
        // Out-of-range program writes must not alias onto in-range words.
        prog_word(1, BASE_B + 32'(4 * WORDS_B), 32'hBAD0_BAD0);
        prog_word(1, BASE_B - 32'h10, 32'hBAD1_BAD1);
        checked_fetch(1, BASE_B, MEM_LW);
        checked_fetch(1, BASE_B + 32'(4 * 60), MEM_LW);
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        drive_req(0, 32'h8, MEM_LW);
        @(negedge clk);
        reset_a = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (rsp_a.ready !== 1'b0) $display("FAIL midreset_ready: got %b expected 0", rsp_a.ready);
        else pass_cnt++;
        total_cnt++;
        if (rsp_a.data !== 32'h0) $display("FAIL midreset_data: got %h expected 0", rsp_a.data);
        else pass_cnt++;
        total_cnt++;
        if (fault_a !== 1'b0) $display("FAIL midreset_fault: got %b expected 0", fault_a);
        else pass_cnt++;
        total_cnt++;
        if (fault_addr_a !== 32'h0) $display("FAIL midreset_fault_addr: got %h expected 0", fault_addr_a);
        else pass_cnt++;
        reset_a = 1'b0;
        drive_req(0, 32'hFFFF_FFF0, MEM_NOP);
        exp_fault[0] = 1'b0;
        exp_fault_addr[0] = 32'h0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            if (rsp_a.ready) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0) $display("FAIL midreset_abandoned: got a ready, expected none");
        else pass_cnt++;
        checked_fetch(0, 32'h8, MEM_LW);
    endtask

    task automatic test_read_first();
        logic [31:0] addr, old_word, exp;
        int lat;
        logic [31:0] data;
        addr = BASE_B + 32'hC;
        old_word = ref_b[3];
        @(negedge clk);
        drive_req(1, addr, MEM_LW);
        set_prog(1, 1'b1, addr, 32'hDEAD_BEEF);
        ref_prog(1, addr, 32'hDEAD_BEEF);
        @(negedge clk);
        set_prog(1, 1'b0, 32'h0, 32'h0);
        #1;
        total_cnt++;
        if (rsp_b.ready !== 1'b1) $display("FAIL readfirst_ready: got %b expected 1", rsp_b.ready);
        else pass_cnt++;
        total_cnt++;
        if (rsp_b.data !== old_word) $display("FAIL readfirst_old: got %h expected %h", rsp_b.data, old_word);
        else pass_cnt++;
        ref_fetch(1, addr, MEM_LW, exp);
        fetch(1, addr, MEM_LW, lat, data);
        total_cnt++;
        if (data !== 32'hDEAD_BEEF || data !== exp) $display("FAIL readfirst_new: got %h expected %h", data, 32'hDEAD_BEEF);
        else pass_cnt++;
        idle(1, 1);
    endtask

    task automatic test_random();
        bit sel;
        int kind, idx, idx_b;
        logic [31:0] base, addr;
        for (int it = 0; it < 80; it++) begin
            sel  = 1'($urandom_range(0, 1));
            kind = int'($urandom_range(0, 11));
            base = base_of(sel);
            idx  = int'($urandom_range(0, 63));
            addr = base + 32'(4 * idx);
            if (kind <= 5) begin
                checked_fetch(sel, addr, MEM_LW);
            end else if (kind == 6) begin
                checked_fetch(sel, addr + 32'($urandom_range(1, 3)), MEM_LW);
            end else if (kind == 7) begin
                checked_fetch(sel, base + 32'(4 * words_of(sel)) + 32'(4 * $urandom_range(0, 255)), MEM_LW);
            end else if (kind == 8) begin
                checked_fetch(sel, addr, MEM_SW);
            end else if (kind == 9) begin
                prog_word(sel, addr, $urandom);
                checked_fetch(sel, addr, MEM_LW);
            end else begin
                idx_b = (idx + 1 + int'($urandom_range(0, 61))) % 64;
                test_abort(sel, addr, base + 32'(4 * idx_b), int'($urandom_range(1, ws_of(sel) + 1)));
            end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_fetch();
        preload();
        test_back_to_back(0);
        test_back_to_back(1);
        test_abort(0, 32'h10, 32'h40, 1);
        test_abort(0, 32'h20, 32'h44, 2);
        test_abort(1, BASE_B + 32'h8, BASE_B + 32'h30, 1);
        test_illegal();
        test_reset_mid();
        test_read_first();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
